// File: rtl/branch_target_buffer_pkg.sv
// Shared predictor definitions: 2-bit counter states, table entry layout and
// the saturating counter step used by the branch target buffer.
package branch_target_buffer_pkg;

  localparam int BTB_MAX_PC_W = 32;

  localparam logic [1:0] ST_SNT = 2'b00;
  localparam logic [1:0] ST_WNT = 2'b01;
  localparam logic [1:0] ST_WT  = 2'b10;
  localparam logic [1:0] ST_ST  = 2'b11;

  // Tag is held zero-extended so one entry layout serves any table depth.
  typedef struct packed {
    logic                    valid;
    logic [BTB_MAX_PC_W-1:0] tag;
    logic [BTB_MAX_PC_W-1:0] target;
    logic [1:0]              ctr;
  } btb_entry_t;

  function automatic logic [1:0] sat2_next(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == ST_ST)  ? ST_ST  : ctr + 2'b01;
    else       return (ctr == ST_SNT) ? ST_SNT : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: zero-latency lookup for fetch, trained by
// resolved branches from EX, plus a saturating misprediction counter.
import branch_target_buffer_pkg::*;

module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_hit,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            ex_valid,
  input  logic [PC_W-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [PC_W-1:0] ex_target,
  input  logic            ex_mispredict,
  input  logic            clear,
  output logic [31:0]     mispredict_cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam int CNT_W = 32;

  if (ENTRIES < 2 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
    $error("branch_target_buffer: ENTRIES must be a power of two >= 2");
  end
  if (PC_W > BTB_MAX_PC_W || TAG_W < 1) begin : g_bad_pc_w
    $error("branch_target_buffer: PC_W out of range for the entry layout");
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  btb_entry_t       tbl [ENTRIES];
  logic [CNT_W-1:0] mispredict_cnt_q;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  btb_entry_t       lk_e;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  btb_entry_t       up_e;
  logic             up_hit;
  logic             unused_pc_lsbs;

  // Word-aligned PCs: the two low bits never select or tag an entry.
  assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[PC_W-1:IDX_W+2];
  assign lk_e   = tbl[lk_idx];

  assign pred_hit    = lk_e.valid && (lk_e.tag == BTB_MAX_PC_W'(lk_tag));
  assign pred_taken  = pred_hit && lk_e.ctr[1];
  assign pred_target = pred_taken ? lk_e.target[PC_W-1:0] : if_pc + PC_W'(4);

  assign up_idx = ex_pc[IDX_W+1:2];
  assign up_tag = ex_pc[PC_W-1:IDX_W+2];
  assign up_e   = tbl[up_idx];
  assign up_hit = up_e.valid && (up_e.tag == BTB_MAX_PC_W'(up_tag));

  assign mispredict_cnt = mispredict_cnt_q;

  // Clear wins over a same-cycle update; lookups never see a bypassed write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      mispredict_cnt_q <= sat_inc(mispredict_cnt_q, ex_valid && ex_mispredict);
      if (clear) begin
        for (int i = 0; i < ENTRIES; i++) begin
          tbl[i].valid <= 1'b0;
          tbl[i].ctr   <= ST_SNT;
        end
      end else if (ex_valid) begin
        if (up_hit) begin
          tbl[up_idx].ctr <= sat2_next(up_e.ctr, ex_taken);
          if (ex_taken) tbl[up_idx].target <= BTB_MAX_PC_W'(ex_target);
        end else if (ex_taken) begin
          tbl[up_idx].valid  <= 1'b1;
          tbl[up_idx].tag    <= BTB_MAX_PC_W'(up_tag);
          tbl[up_idx].target <= BTB_MAX_PC_W'(ex_target);
          tbl[up_idx].ctr    <= ST_WT;
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Bench for branch_target_buffer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an array-based model.
module tb_branch_target_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] if_pc = 32'h100;
  logic        pred_hit, pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic        ex_taken = 1'b0;
  logic [31:0] ex_target = '0;
  logic        ex_mispredict = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] mispredict_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;
  bit preload = 1'b0;

  branch_target_buffer dut (
    .clk(clk), .reset(reset), .if_pc(if_pc),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
    .ex_mispredict(ex_mispredict), .clear(clear), .mispredict_cnt(mispredict_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: 16 direct-mapped slots, index = word address mod 16,
  // tag = pc / 64, counter kept as an integer 0..3.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_target[16];
  int          m_ctr   [16];
  logic [31:0] m_cnt = '0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 16);
  endfunction
  function automatic int unsigned tag_of(input logic [31:0] pc);
    return pc / 64;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) begin
        m_valid[i] <= 1'b0; m_tag[i] <= 0; m_target[i] <= '0; m_ctr[i] <= 0;
      end
      m_cnt <= '0;
    end else begin
      if (preload) m_cnt <= 32'hFFFF_FFFD;
      else if (ex_valid && ex_mispredict && m_cnt != 32'hFFFF_FFFF) m_cnt <= m_cnt + 1;
      if (clear) begin
        for (int i = 0; i < 16; i++) begin
          m_valid[i] <= 1'b0; m_ctr[i] <= 0;
        end
      end else if (ex_valid) begin
        if (m_valid[idx_of(ex_pc)] && m_tag[idx_of(ex_pc)] == tag_of(ex_pc)) begin
          if (ex_taken) begin
            m_ctr[idx_of(ex_pc)]    <= (m_ctr[idx_of(ex_pc)] < 3) ? m_ctr[idx_of(ex_pc)] + 1 : 3;
            m_target[idx_of(ex_pc)] <= ex_target;
          end else begin
            m_ctr[idx_of(ex_pc)]    <= (m_ctr[idx_of(ex_pc)] > 0) ? m_ctr[idx_of(ex_pc)] - 1 : 0;
          end
        end else if (ex_taken) begin
          m_valid[idx_of(ex_pc)]  <= 1'b1;
          m_tag[idx_of(ex_pc)]    <= tag_of(ex_pc);
          m_target[idx_of(ex_pc)] <= ex_target;
          m_ctr[idx_of(ex_pc)]    <= 2;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int          k;
    bit          e_hit, e_taken;
    logic [31:0] e_tgt;
    if (cmp_en) begin
      k       = idx_of(if_pc);
      e_hit   = m_valid[k] && (m_tag[k] == tag_of(if_pc));
      e_taken = e_hit && (m_ctr[k] >= 2);
      e_tgt   = e_taken ? m_target[k] : if_pc + 32'd4;
      chk("model_hit",    32'(pred_hit),   32'(e_hit));
      chk("model_taken",  32'(pred_taken), 32'(e_taken));
      chk("model_target", pred_target,     e_tgt);
      chk("model_cnt",    mispredict_cnt,  m_cnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic ex(input bit v, input logic [31:0] pc, input bit tk,
                    input logic [31:0] tgt, input bit mp);
    ex_valid = v; ex_pc = pc; ex_taken = tk; ex_target = tgt; ex_mispredict = mp;
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                     input bit mp, input int n);
    ex(1'b1, pc, tk, tgt, mp);
    for (int i = 0; i < n; i++) cyc();
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic look(input string name, input logic [31:0] pc, input bit hit,
                      input bit tk, input logic [31:0] tgt);
    if_pc = pc;
    settle();
    chk({name, "_hit"},    32'(pred_hit),   32'(hit));
    chk({name, "_taken"},  32'(pred_taken), 32'(tk));
    chk({name, "_target"}, pred_target,     tgt);
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(7) != 0)
      return 32'h1000 + ($urandom_range(3) << 6) + ($urandom_range(15) << 2);
    return $urandom;
  endfunction

  initial begin
    #1 reset = 1'b1;
    #1 cmp_en = 1'b1;
    #1;
    chk("reset_hit",    32'(pred_hit),   32'h0);
    chk("reset_taken",  32'(pred_taken), 32'h0);
    chk("reset_target", pred_target,     32'h104);
    chk("reset_cnt",    mispredict_cnt,  32'h0);
    cyc();
    reset = 1'b0;

    // Allocation on taken miss, then counter saturation both ways.
    if_pc = 32'h100;
    ex(1'b1, 32'h100, 1'b1, 32'h200, 1'b0);
    settle();
    chk("alloc_pre_hit", 32'(pred_hit), 32'h0);
    cyc();
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 1'b1, 32'h200, 1'b0, 2);
    look("sat_st", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 1);
    look("nt1", 32'h100, 1'b1, 1'b1, 32'h200);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 1);
    look("nt2", 32'h100, 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 1);
    look("nt3", 32'h100, 1'b1, 1'b0, 32'h104);

    // Not-taken miss allocates nothing and leaves the aliased entry alone.
    upd(32'h300, 1'b0, 32'h0, 1'b0, 1);
    look("nt_miss", 32'h300, 1'b0, 1'b0, 32'h304);
    look("nt_miss_keep", 32'h100, 1'b1, 1'b0, 32'h104);

    // Alias eviction at index 0.
    upd(32'h100, 1'b1, 32'h200, 1'b0, 1);
    upd(32'h140, 1'b1, 32'h500, 1'b0, 1);
    look("evict_old", 32'h100, 1'b0, 1'b0, 32'h104);
    look("evict_new", 32'h140, 1'b1, 1'b1, 32'h500);
    upd(32'h140, 1'b0, 32'h0, 1'b0, 1);
    look("evict_ctr_wt", 32'h140, 1'b1, 1'b0, 32'h144);

    // Clear overrides a same-cycle update; no lookup bypass.
    clear = 1'b1;
    upd(32'h100, 1'b1, 32'h700, 1'b0, 1);
    clear = 1'b0;
    look("clear_a", 32'h140, 1'b0, 1'b0, 32'h144);
    look("clear_b", 32'h100, 1'b0, 1'b0, 32'h104);
    ex(1'b1, 32'h100, 1'b1, 32'h600, 1'b0);
    look("nobypass_old", 32'h100, 1'b0, 1'b0, 32'h104);
    cyc();
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    look("nobypass_new", 32'h100, 1'b1, 1'b1, 32'h600);

    // Misprediction counter.
    ex(1'b0, 32'h200, 1'b0, 32'h0, 1'b1);
    cyc();
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    settle();
    chk("cnt_gated", mispredict_cnt, 32'h0);
    upd(32'h200, 1'b0, 32'h0, 1'b1, 5);
    settle();
    chk("cnt_five", mispredict_cnt, 32'h5);
    clear = 1'b1;
    cyc();
    clear = 1'b0;
    settle();
    chk("cnt_clear", mispredict_cnt, 32'h5);

    cmp_en = 1'b0;
    force dut.mispredict_cnt_q = 32'hFFFF_FFFD;
    preload = 1'b1;
    cyc();
    preload = 1'b0;
    release dut.mispredict_cnt_q;
    settle();
    cmp_en = 1'b1;
    upd(32'h200, 1'b0, 32'h0, 1'b1, 4);
    settle();
    chk("cnt_sat", mispredict_cnt, 32'hFFFF_FFFF);

    ex(1'b1, 32'h200, 1'b0, 32'h0, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_cnt", mispredict_cnt, 32'h0);
    chk("async_rst_hit", 32'(pred_hit), 32'h0);
    #1 reset = 1'b0;
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    // Randomized traffic, checked every cycle by the compare process.
    for (int n = 0; n < 3000; n++) begin
      cyc();
      if_pc         = rand_pc();
      ex_valid      = ($urandom_range(3) != 0);
      ex_pc         = rand_pc();
      ex_taken      = $urandom_range(1) == 1;
      ex_target     = $urandom;
      ex_mispredict = $urandom_range(1) == 1;
      clear         = ($urandom_range(63) == 0);
      if ($urandom_range(499) == 0) begin
        #1 reset = 1'b1;
        #1 reset = 1'b0;
      end
    end
    cyc();
    ex(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    clear = 1'b0;
    cyc();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
